systolic_result_collector: RTL and testbench
============================================

Name: systolic_result_collector

Overview:
- Receiving end of the systolic array result stream: consumes the serialized c_dout / c_dout_idx / out_valid stream, one signed element per valid cycle.
- Reassembles the elements into an N x N result matrix buffer.
- Drains the buffer one row per transfer over a valid/ready handshake toward the writeback path.
- Sits between the array's output stage and the result memory or scoreboard.

Parameters:
- DIN_WIDTH, 8, operand width; result element width is 2*DIN_WIDTH (signed).
- N, 4, array dimension; must be >= 2 (c_dout_idx width is $clog2(N)).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- out_valid  input  1  c_dout/c_dout_idx carry a valid element this cycle.
- c_dout  input  2*DIN_WIDTH  signed result element.
- c_dout_idx  input  $clog2(N)  column index of c_dout within the current row.
- row_valid  output  1  row_data holds a complete row.
- row_ready  input  1  downstream accepts the row when row_valid && row_ready.
- row_data  output  N*2*DIN_WIDTH  row elements; column j at bits [j*2*DIN_WIDTH +: 2*DIN_WIDTH].
- row_idx  output  $clog2(N)  index of the row on row_data.
- row_last  output  1  asserted with row_valid when row_idx == N-1.
- frame_done  output  1  one-cycle pulse on the cycle the last row is accepted.
- busy  output  1  high in DRAIN.
- seq_err  output  1  sticky: element arrived out of order.
- ovf_err  output  1  sticky: element arrived during DRAIN.

Behaviour:
- Reset (async assert, sync-style release):
  - State FILL; write row/col counters 0; read row counter 0.
  - row_valid, row_last, frame_done, busy, seq_err, ovf_err = 0.
  - Buffer contents are don't-care; row_data = 0 while row_valid = 0.
- Storage: N x N registers, each 2*DIN_WIDTH signed. Stored verbatim; no arithmetic or saturation.
- FILL state:
  - On out_valid, write c_dout to buf[wr_row][wr_col].
  - If c_dout_idx != wr_col: the element is still written at wr_col, and seq_err is set (sticky). Stream position, not the index, is authoritative.
  - wr_col increments and wraps N-1 -> 0; wr_row increments on that wrap.
  - When the element at (N-1, N-1) is written: next state DRAIN, wr counters reset to 0, rd_row = 0.
- DRAIN state:
  - busy = 1; row_valid = 1 starting the cycle after entry (registered).
  - row_data = buf[rd_row]; row_idx = rd_row; row_last = (rd_row == N-1).
  - row_data, row_idx and row_last stay stable while row_valid && !row_ready.
  - On handshake: rd_row++.
  - If handshake happens with row_last: frame_done pulses for 1 cycle in the same cycle, row_valid drops the next cycle, state returns to FILL.
- Latency: last element captured at edge k; row 0 is valid after edge k. With row_ready held 1, rows are accepted on N consecutive cycles. Minimum frame period is N*N + N cycles.
- out_valid in DRAIN: element dropped, ovf_err set (sticky), buffer unchanged.
- out_valid on the same cycle as the final handshake: state is still DRAIN, so the element is dropped and ovf_err is set. The next frame starts the cycle after.
- seq_err and ovf_err clear only on reset.
- Reset mid-frame or mid-drain: all state is discarded immediately; the partial frame is lost; no frame_done is emitted.
- row_ready is ignored outside DRAIN.

Test Plan:
- Basic frame: N=4, DIN_WIDTH=8, stream c = 16 values -100, -99, ... with idx 0,1,2,3 repeating, row_ready=1 -> rows 0..3 emitted on 4 consecutive cycles. Row 0 = {-97,-98,-99,-100} (MSB..LSB). row_last only on row 3. frame_done pulses once. seq_err = 0, ovf_err = 0.
- Backpressure: same frame, row_ready = 0 for 5 cycles, then toggled 1,0,1,0,... -> row_data/row_idx stable while stalled. Each row is delivered exactly once, in order 0..3.
- Boundary values: elements 32767 and -32768 alternating -> stored and emitted bit-exact, including sign.
- Sequence error: idx sequence 0,1,3,3 in row 0 -> seq_err = 1 after the third element. Element placement stays positional (col 2 holds the third value). seq_err remains 1 through the next frame.
- Overflow: out_valid = 1 with c_dout = 555 during DRAIN, including the final-handshake cycle -> ovf_err = 1. Value 555 appears in no emitted row. The following frame is collected correctly.
- Reset mid-operation: assert rst_n = 0 after 7 elements, then again during row 2 drain -> outputs return to reset values asynchronously. The next full frame drains rows 0..3 correctly with no stale data.

Source files
------------

// File: rtl/systolic_result_collector.sv
// Collects the serialized systolic-array result stream into an N x N buffer
// and drains it one row per valid/ready transfer toward writeback.
module systolic_result_collector #(
    parameter int DIN_WIDTH = 8,
    parameter int N         = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          out_valid,
    input  logic signed [2*DIN_WIDTH-1:0] c_dout,
    input  logic [$clog2(N)-1:0]          c_dout_idx,
    output logic                          row_valid,
    input  logic                          row_ready,
    output logic [N*2*DIN_WIDTH-1:0]      row_data,
    output logic [$clog2(N)-1:0]          row_idx,
    output logic                          row_last,
    output logic                          frame_done,
    output logic                          busy,
    output logic                          seq_err,
    output logic                          ovf_err
);

    localparam int EW = 2 * DIN_WIDTH;
    localparam int IW = $clog2(N);
    localparam int RW = N * EW;
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_ZERO = IW'(0);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [RW-1:0]  buf_r [N];
    logic [IW-1:0]  wr_row_r;
    logic [IW-1:0]  wr_col_r;
    logic [IW-1:0]  rd_row_r;
    logic [IW-1:0]  rd_row_next_s;
    logic [IW-1:0]  rd_inc_s;
    logic           row_valid_r;
    logic           row_valid_next_s;
    logic [RW-1:0]  row_data_r;
    logic [RW-1:0]  row_data_next_s;
    logic           row_last_r;
    logic           row_last_next_s;
    logic           seq_err_r;
    logic           ovf_err_r;
    logic           fill_wr_s;
    logic           col_wrap_s;
    logic           fill_last_s;
    logic           hs_s;
    logic           final_hs_s;

    assign fill_wr_s   = (state_r == ST_FILL) && out_valid;
    assign col_wrap_s  = (wr_col_r == IDX_LAST);
    assign fill_last_s = fill_wr_s && col_wrap_s && (wr_row_r == IDX_LAST);
    assign hs_s        = row_valid_r && row_ready;
    assign final_hs_s  = hs_s && row_last_r;
    assign rd_inc_s    = rd_row_r + IDX_ONE;

    // Next-state logic for the fill/drain controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (fill_last_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (final_hs_s) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: state_next_s = ST_FILL;
        endcase
    end

    // Next values of the registered row interface; the buffer is frozen while
    // draining, so the following row can be read straight out of it.
    always_comb begin
        row_valid_next_s = row_valid_r;
        row_data_next_s  = row_data_r;
        row_last_next_s  = row_last_r;
        rd_row_next_s    = rd_row_r;
        case (state_r)
            ST_FILL: begin
                if (fill_last_s) begin
                    row_valid_next_s = 1'b1;
                    row_data_next_s  = buf_r[0];
                    row_last_next_s  = 1'b0;
                    rd_row_next_s    = IDX_ZERO;
                end else begin
                    row_valid_next_s = 1'b0;
                    row_data_next_s  = {RW{1'b0}};
                    row_last_next_s  = 1'b0;
                    rd_row_next_s    = IDX_ZERO;
                end
            end
            ST_DRAIN: begin
                if (final_hs_s) begin
                    row_valid_next_s = 1'b0;
                    row_data_next_s  = {RW{1'b0}};
                    row_last_next_s  = 1'b0;
                    rd_row_next_s    = IDX_ZERO;
                end else if (hs_s) begin
                    row_valid_next_s = 1'b1;
                    row_data_next_s  = buf_r[rd_inc_s];
                    row_last_next_s  = (rd_inc_s == IDX_LAST);
                    rd_row_next_s    = rd_inc_s;
                end else begin
                    row_valid_next_s = row_valid_r;
                    row_data_next_s  = row_data_r;
                    row_last_next_s  = row_last_r;
                    rd_row_next_s    = rd_row_r;
                end
            end
            default: begin
                row_valid_next_s = 1'b0;
                row_data_next_s  = {RW{1'b0}};
                row_last_next_s  = 1'b0;
                rd_row_next_s    = IDX_ZERO;
            end
        endcase
    end

    // Control state, counters, row interface and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_FILL;
            wr_row_r    <= IDX_ZERO;
            wr_col_r    <= IDX_ZERO;
            rd_row_r    <= IDX_ZERO;
            row_valid_r <= 1'b0;
            row_data_r  <= {RW{1'b0}};
            row_last_r  <= 1'b0;
            seq_err_r   <= 1'b0;
            ovf_err_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            rd_row_r    <= rd_row_next_s;
            row_valid_r <= row_valid_next_s;
            row_data_r  <= row_data_next_s;
            row_last_r  <= row_last_next_s;
            if (fill_wr_s) begin
                if (col_wrap_s) begin
                    wr_col_r <= IDX_ZERO;
                    wr_row_r <= (wr_row_r == IDX_LAST) ? IDX_ZERO : (wr_row_r + IDX_ONE);
                end else begin
                    wr_col_r <= wr_col_r + IDX_ONE;
                end
            end
            // Stream position wins over the index; a mismatch is only flagged.
            if (fill_wr_s && (c_dout_idx != wr_col_r)) begin
                seq_err_r <= 1'b1;
            end
            if ((state_r == ST_DRAIN) && out_valid) begin
                ovf_err_r <= 1'b1;
            end
        end
    end

    // Result storage; contents are don't-care after reset so it carries none.
    always_ff @(posedge clk) begin
        if (fill_wr_s) begin
            buf_r[wr_row_r][wr_col_r*EW +: EW] <= c_dout;
        end
    end

    assign row_valid  = row_valid_r;
    assign row_data   = row_data_r;
    assign row_idx    = rd_row_r;
    assign row_last   = row_last_r;
    assign frame_done = final_hs_s;
    assign busy       = (state_r == ST_DRAIN);
    assign seq_err    = seq_err_r;
    assign ovf_err    = ovf_err_r;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed bench for systolic_result_collector (N=4, DIN_WIDTH=8).
module tb_systolic_result_collector;

    logic               clk;
    logic               rst_n;
    logic               out_valid;
    logic signed [15:0] c_dout;
    logic [1:0]         c_dout_idx;
    logic               row_valid;
    logic               row_ready;
    logic [63:0]        row_data;
    logic [1:0]         row_idx;
    logic               row_last;
    logic               frame_done;
    logic               busy;
    logic               seq_err;
    logic               ovf_err;

    int checks = 0;
    int errors = 0;

    systolic_result_collector #(.DIN_WIDTH(8), .N(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .out_valid  (out_valid),
        .c_dout     (c_dout),
        .c_dout_idx (c_dout_idx),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_data   (row_data),
        .row_idx    (row_idx),
        .row_last   (row_last),
        .frame_done (frame_done),
        .busy       (busy),
        .seq_err    (seq_err),
        .ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
    endfunction

    task automatic send_elem(input int v, input int ix);
        out_valid  = 1'b1;
        c_dout     = v[15:0];
        c_dout_idx = ix[1:0];
        @(negedge clk);
    endtask

    task automatic send_frame(input int base, input bit alt, input bit seqm);
        int v;
        int ix;
        for (int i = 0; i < 16; i++) begin
            v  = alt ? ((i % 2 == 0) ? 32767 : -32768) : (base + i);
            ix = (seqm && i == 2) ? 3 : (i % 4);
            send_elem(v, ix);
            if (seqm && i < 3) chk("seq_err_progress", seq_err, (i == 2));
        end
        out_valid = 1'b0;
    endtask

    task automatic drain(input logic [63:0] r0, input logic [63:0] r1,
                         input logic [63:0] r2, input logic [63:0] r3,
                         input bit stall, input bit inject);
        logic [63:0] rows [4];
        int nxt;
        int c;
        rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
        nxt = 0;
        c   = 0;
        while (nxt < 4 && c < 40) begin
            row_ready = stall ? (c >= 5 && ((c - 5) % 2 == 0)) : 1'b1;
            if (inject) begin
                out_valid  = 1'b1;
                c_dout     = 16'sd555;
                c_dout_idx = 2'd0;
            end
            #1;
            chk("row_valid", row_valid, 1'b1);
            chk("busy_drain", busy, 1'b1);
            chk("row_idx", row_idx, nxt);
            chk("row_data", row_data, rows[nxt]);
            chk("row_last", row_last, (nxt == 3));
            if (row_ready) begin
                chk("frame_done", frame_done, (nxt == 3));
                nxt++;
            end else begin
                chk("frame_done_stall", frame_done, 1'b0);
            end
            c++;
            @(negedge clk);
        end
        if (nxt < 4) chk("drain_timeout", nxt, 4);
        out_valid = 1'b0;
        #1;
        chk("post_row_valid", row_valid, 1'b0);
        chk("post_busy", busy, 1'b0);
        chk("post_frame_done", frame_done, 1'b0);
        chk("post_row_data", row_data, 64'h0);
        if (inject) chk("ovf_err", ovf_err, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        out_valid  = 1'b0;
        c_dout     = 16'sd0;
        c_dout_idx = 2'd0;
        row_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_row_valid", row_valid, 1'b0);
        chk("rst_row_data", row_data, 64'h0);
        chk("rst_row_idx", row_idx, 2'd0);
        chk("rst_row_last", row_last, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_seq_err", seq_err, 1'b0);
        chk("rst_ovf_err", ovf_err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame, ready held high
        row_ready = 1'b1;
        send_frame(-100, 1'b0, 1'b0);
        drain(64'hFF9F_FF9E_FF9D_FF9C, pack4(-96, -95, -94, -93),
              pack4(-92, -91, -90, -89), pack4(-88, -87, -86, -85), 1'b0, 1'b0);
        chk("basic_seq_err", seq_err, 1'b0);
        chk("basic_ovf_err", ovf_err, 1'b0);

        // Backpressure
        send_frame(-100, 1'b0, 1'b0);
        drain(64'hFF9F_FF9E_FF9D_FF9C, pack4(-96, -95, -94, -93),
              pack4(-92, -91, -90, -89), pack4(-88, -87, -86, -85), 1'b1, 1'b0);

        // Boundary values
        send_frame(0, 1'b1, 1'b0);
        drain(64'h8000_7FFF_8000_7FFF, 64'h8000_7FFF_8000_7FFF,
              64'h8000_7FFF_8000_7FFF, 64'h8000_7FFF_8000_7FFF, 1'b0, 1'b0);
        chk("boundary_seq_err", seq_err, 1'b0);

        // Sequence error: idx 0,1,3,3 in row 0, placement stays positional
        send_frame(1, 1'b0, 1'b1);
        drain(64'h0004_0003_0002_0001, pack4(5, 6, 7, 8),
              pack4(9, 10, 11, 12), pack4(13, 14, 15, 16), 1'b0, 1'b0);
        chk("seq_err_sticky", seq_err, 1'b1);
        chk("seq_ovf_clear", ovf_err, 1'b0);

        // Overflow: 555 injected every drain cycle, including the final handshake
        send_frame(40, 1'b0, 1'b0);
        drain(pack4(40, 41, 42, 43), pack4(44, 45, 46, 47),
              pack4(48, 49, 50, 51), pack4(52, 53, 54, 55), 1'b1, 1'b1);
        chk("seq_err_next_frame", seq_err, 1'b1);
        send_frame(100, 1'b0, 1'b0);
        drain(pack4(100, 101, 102, 103), pack4(104, 105, 106, 107),
              pack4(108, 109, 110, 111), pack4(112, 113, 114, 115), 1'b0, 1'b0);
        chk("ovf_err_sticky", ovf_err, 1'b1);

        // Reset after 7 elements
        for (int i = 0; i < 7; i++) send_elem(900 + i, i % 4);
        out_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midfill_seq_err", seq_err, 1'b0);
        chk("midfill_ovf_err", ovf_err, 1'b0);
        chk("midfill_row_valid", row_valid, 1'b0);
        chk("midfill_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full frame, then reset while row 2 is on the bus
        row_ready = 1'b1;
        send_frame(200, 1'b0, 1'b0);
        #1 chk("rd_row0", row_data, pack4(200, 201, 202, 203));
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rd_row2_idx", row_idx, 2'd2);
        chk("rd_row2_data", row_data, pack4(208, 209, 210, 211));
        #1 rst_n = 1'b0;
        #1;
        chk("middrain_row_valid", row_valid, 1'b0);
        chk("middrain_row_idx", row_idx, 2'd0);
        chk("middrain_row_data", row_data, 64'h0);
        chk("middrain_row_last", row_last, 1'b0);
        chk("middrain_busy", busy, 1'b0);
        chk("middrain_frame_done", frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send_frame(300, 1'b0, 1'b0);
        drain(pack4(300, 301, 302, 303), pack4(304, 305, 306, 307),
              pack4(308, 309, 310, 311), pack4(312, 313, 314, 315), 1'b0, 1'b0);
        chk("final_seq_err", seq_err, 1'b0);
        chk("final_ovf_err", ovf_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
